// File: rtl/verificador_contador.sv
// rtl/verificador_contador.sv - mod-(MAX_VAL+1) count stream checker
// Locks onto a 0..MAX_VAL ramp, flywheels through isolated misses and counts mismatches.
module verificador_contador #(
   parameter int WIDTH       = 3,
   parameter int MAX_VAL     = 4,
   parameter int LOCK_CNT    = 3,
   parameter int UNLOCK_ERRS = 2,
   parameter int ERR_W       = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             sample_en,
   input  logic [WIDTH-1:0] S_in,
   input  logic             clear_err,
   output logic             locked,
   output logic             err,
   output logic             wrap,
   output logic [WIDTH-1:0] expected,
   output logic [ERR_W-1:0] err_count
);

   localparam int RUN_W  = $clog2(LOCK_CNT + 1);
   localparam int MISS_W = $clog2(UNLOCK_ERRS + 1);

   typedef enum logic [1:0] {HUNT, LOCKED, SUSPECT} state_t;

   state_t             state, state_n;
   logic [RUN_W-1:0]   run, run_n;
   logic [MISS_W-1:0]  miss, miss_n;
   logic [WIDTH-1:0]   prev, prev_n;
   logic               prev_valid, prev_valid_n;
   logic [WIDTH-1:0]   expected_n;
   logic               err_n, wrap_n, cnt_inc;
   logic [ERR_W-1:0]   err_count_n;
   logic               legal;

   function automatic logic [WIDTH-1:0] next_of(input logic [WIDTH-1:0] x);
      return (x == WIDTH'(MAX_VAL)) ? '0 : x + 1'b1;
   endfunction

   assign legal = (S_in <= WIDTH'(MAX_VAL));

   always_comb begin
      state_n      = state;
      run_n        = run;
      miss_n       = miss;
      prev_n       = prev;
      prev_valid_n = prev_valid;
      expected_n   = expected;
      err_n        = 1'b0;
      wrap_n       = 1'b0;
      cnt_inc      = 1'b0;
      if (sample_en) begin
         case (state)
            HUNT: begin
               if (!legal) begin
                  run_n        = '0;
                  prev_valid_n = 1'b0;
               end else begin
                  if (prev_valid && S_in == next_of(prev)) begin
                     if (int'(run) + 1 == LOCK_CNT) begin
                        state_n    = LOCKED;
                        expected_n = next_of(S_in);
                        run_n      = '0;
                     end else begin
                        run_n = run + 1'b1;
                     end
                  end else begin
                     run_n = '0;
                  end
                  prev_n       = S_in;
                  prev_valid_n = 1'b1;
               end
            end
            default: begin
               // LOCKED and SUSPECT share handling; miss is 0 in LOCKED
               if (S_in == expected) begin
                  state_n    = LOCKED;
                  miss_n     = '0;
                  expected_n = next_of(expected);
                  wrap_n     = (S_in == '0);
               end else begin
                  err_n   = 1'b1;
                  cnt_inc = 1'b1;
                  if (int'(miss) + 1 == UNLOCK_ERRS) begin
                     state_n      = HUNT;
                     run_n        = '0;
                     miss_n       = '0;
                     prev_n       = S_in;
                     prev_valid_n = legal;
                     expected_n   = '0;
                  end else begin
                     state_n    = SUSPECT;
                     miss_n     = miss + 1'b1;
                     expected_n = next_of(expected);
                  end
               end
            end
         endcase
      end
      if (clear_err)
         err_count_n = '0;
      else if (cnt_inc && err_count != '1)
         err_count_n = err_count + 1'b1;
      else
         err_count_n = err_count;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= HUNT;
         run        <= '0;
         miss       <= '0;
         prev       <= '0;
         prev_valid <= 1'b0;
         locked     <= 1'b0;
         err        <= 1'b0;
         wrap       <= 1'b0;
         expected   <= '0;
         err_count  <= '0;
      end else begin
         state      <= state_n;
         run        <= run_n;
         miss       <= miss_n;
         prev       <= prev_n;
         prev_valid <= prev_valid_n;
         locked     <= (state_n != HUNT);
         err        <= err_n;
         wrap       <= wrap_n;
         expected   <= expected_n;
         err_count  <= err_count_n;
      end
   end

endmodule

// File: tb/tb_verificador_contador.sv
// tb/tb_verificador_contador.sv - self-checking bench for verificador_contador
module tb_verificador_contador;

   localparam int LOCK_CNT    = 3;
   localparam int UNLOCK_ERRS = 2;

   logic       clock;
   logic       reset_n;
   logic       sample_en;
   logic [2:0] S_in;
   logic       clear_err;
   logic       locked;
   logic       err;
   logic       wrap;
   logic [2:0] expected;
   logic [7:0] err_count;

   int total = 0;
   int bad   = 0;

   // reference model: mode 0=hunting, 1=locked, 2=suspect
   int chain[$];
   int mode;
   int exp_m;
   int miss_m;
   int cnt_m;
   bit err_m;
   bit wrap_m;

   verificador_contador dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .sample_en (sample_en),
      .S_in      (S_in),
      .clear_err (clear_err),
      .locked    (locked),
      .err       (err),
      .wrap      (wrap),
      .expected  (expected),
      .err_count (err_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void model_reset();
      chain.delete();
      mode   = 0;
      exp_m  = 0;
      miss_m = 0;
      cnt_m  = 0;
      err_m  = 0;
      wrap_m = 0;
   endfunction

   function automatic void model_step(input bit en, input int s, input bit clr);
      bit legal;
      legal  = (s <= 4);
      err_m  = 0;
      wrap_m = 0;
      if (en) begin
         if (mode == 0) begin
            if (!legal) chain.delete();
            else if (chain.size() > 0 && s == (chain[$] + 1) % 5) chain.push_back(s);
            else begin
               chain.delete();
               chain.push_back(s);
            end
            if (chain.size() == LOCK_CNT + 1) begin
               mode   = 1;
               exp_m  = (s + 1) % 5;
               miss_m = 0;
               chain.delete();
            end
         end else if (s == exp_m) begin
            wrap_m = (s == 0);
            mode   = 1;
            miss_m = 0;
            exp_m  = (exp_m + 1) % 5;
         end else begin
            err_m = 1;
            if (cnt_m < 255) cnt_m++;
            miss_m++;
            if (miss_m == UNLOCK_ERRS) begin
               mode   = 0;
               exp_m  = 0;
               miss_m = 0;
               chain.delete();
               if (legal) chain.push_back(s);
            end else begin
               mode  = 2;
               exp_m = (exp_m + 1) % 5;
            end
         end
      end
      if (clr) cnt_m = 0;
   endfunction

   task automatic drive(input bit en, input int s, input bit clr);
      sample_en = en;
      S_in      = s[2:0];
      clear_err = clr;
      @(posedge clock);
      model_step(en, s, clr);
      @(negedge clock);
   endtask

   task automatic apply_reset();
      sample_en = 0;
      S_in      = 0;
      clear_err = 0;
      reset_n   = 0;
      model_reset();
      repeat (2) @(negedge clock);
      reset_n = 1;
      @(negedge clock);
   endtask

   task automatic test_reset();
      apply_reset();
      total++;
      if (locked !== 1'b0 || err !== 1'b0 || wrap !== 1'b0 || expected !== 3'd0 || err_count !== 8'd0) begin
         bad++;
         $display("FAIL reset: locked=%b err=%b wrap=%b expected=%0d err_count=%0d required all 0",
                  locked, err, wrap, expected, err_count);
      end
   endtask

   task automatic test_lock_sequence();
      int seq[4] = '{0, 1, 2, 3};
      foreach (seq[i]) begin
         drive(1, seq[i], 0);
         total++;
         if (locked !== (mode != 0) || expected !== 3'(exp_m) || err !== 1'b0) begin
            bad++;
            $display("FAIL lock_seq[%0d]: locked=%b expected=%0d err=%b required locked=%0d expected=%0d err=0",
                     i, locked, expected, err, mode != 0, exp_m);
         end
      end
      total++;
      if (locked !== 1'b1 || expected !== 3'd4 || err_count !== 8'd0) begin
         bad++;
         $display("FAIL lock_final: locked=%b expected=%0d err_count=%0d required 1/4/0", locked, expected, err_count);
      end
   endtask

   task automatic test_wrap();
      int seq[3] = '{4, 0, 1};
      foreach (seq[i]) begin
         drive(1, seq[i], 0);
         total++;
         if (wrap !== (seq[i] == 0) || err !== 1'b0 || expected !== 3'(exp_m)) begin
            bad++;
            $display("FAIL wrap[%0d]: wrap=%b err=%b expected=%0d required wrap=%0d err=0 expected=%0d",
                     i, wrap, err, expected, seq[i] == 0, exp_m);
         end
      end
      total++;
      if (expected !== 3'd2) begin
         bad++;
         $display("FAIL wrap_expected: got %0d required 2", expected);
      end
   endtask

   task automatic test_suspect_recover();
      int seq[4] = '{3, 3, 4, 0};
      foreach (seq[i]) begin
         drive(1, seq[i], 0);
         total++;
         if (err !== (i == 0) || locked !== 1'b1 || err_count !== 8'd1) begin
            bad++;
            $display("FAIL suspect[%0d]: err=%b locked=%b err_count=%0d required err=%0d locked=1 count=1",
                     i, err, locked, err_count, i == 0);
         end
      end
   endtask

   task automatic test_unlock_relock();
      int pre[4]  = '{1, 2, 3, 4};
      int post[4] = '{3, 4, 0, 1};
      foreach (pre[i]) drive(1, pre[i], 0);
      total++;
      if (expected !== 3'd0 || locked !== 1'b1) begin
         bad++;
         $display("FAIL unlock_setup: expected=%0d locked=%b required 0/1", expected, locked);
      end
      for (int i = 0; i < 2; i++) begin
         drive(1, 2, 0);
         total++;
         if (err !== 1'b1 || locked !== (i == 0) || err_count !== 8'(2 + i)) begin
            bad++;
            $display("FAIL unlock[%0d]: err=%b locked=%b err_count=%0d required err=1 locked=%0d count=%0d",
                     i, err, locked, err_count, i == 0, 2 + i);
         end
      end
      foreach (post[i]) begin
         drive(1, post[i], 0);
         total++;
         if (locked !== (mode != 0) || expected !== 3'(exp_m) || err !== 1'b0) begin
            bad++;
            $display("FAIL relock[%0d]: locked=%b expected=%0d err=%b required %0d/%0d/0",
                     i, locked, expected, err, mode != 0, exp_m);
         end
      end
      total++;
      if (locked !== 1'b1 || expected !== 3'd2) begin
         bad++;
         $display("FAIL relock_final: locked=%b expected=%0d required 1/2", locked, expected);
      end
   endtask

   task automatic test_hunt_break();
      int seq[7] = '{0, 1, 7, 2, 3, 4, 0};
      apply_reset();
      foreach (seq[i]) begin
         drive(1, seq[i], 0);
         total++;
         if (locked !== (i == 6) || err !== 1'b0) begin
            bad++;
            $display("FAIL hunt[%0d]: locked=%b err=%b required locked=%0d err=0", i, locked, err, i == 6);
         end
      end
      drive(1, 6, 0);
      total++;
      if (err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b1 || expected !== 3'd2) begin
         bad++;
         $display("FAIL illegal_locked: err=%b err_count=%0d locked=%b expected=%0d required 1/1/1/2",
                  err, err_count, locked, expected);
      end
   endtask

   task automatic test_idle_hold();
      for (int i = 0; i < 4; i++) begin
         drive(0, $urandom_range(0, 7), 0);
         total++;
         if (err !== 1'b0 || wrap !== 1'b0 || locked !== 1'b1 || expected !== 3'd2 || err_count !== 8'd1) begin
            bad++;
            $display("FAIL idle[%0d]: err=%b wrap=%b locked=%b expected=%0d count=%0d required 0/0/1/2/1",
                     i, err, wrap, locked, expected, err_count);
         end
      end
      drive(0, 5, 1);
      total++;
      if (err_count !== 8'd0 || locked !== 1'b1) begin
         bad++;
         $display("FAIL idle_clear: err_count=%0d locked=%b required 0/1", err_count, locked);
      end
   endtask

   task automatic test_saturation();
      int guard = 0;
      apply_reset();
      for (int i = 0; i < 4; i++) drive(1, i, 0);
      while (cnt_m < 255 && guard < 1000) begin
         drive(1, (exp_m + 1) % 5, 0);
         drive(1, exp_m, 0);
         guard++;
      end
      total++;
      if (err_count !== 8'd255 || locked !== 1'b1) begin
         bad++;
         $display("FAIL sat_reach: err_count=%0d locked=%b required 255/1", err_count, locked);
      end
      drive(1, (exp_m + 1) % 5, 0);
      total++;
      if (err_count !== 8'd255 || err !== 1'b1) begin
         bad++;
         $display("FAIL sat_hold: err_count=%0d err=%b required 255/1", err_count, err);
      end
      drive(1, (exp_m + 1) % 5, 1);
      total++;
      if (err_count !== 8'd0 || err !== 1'b1 || locked !== 1'b0) begin
         bad++;
         $display("FAIL clear_wins: err_count=%0d err=%b locked=%b required 0/1/0", err_count, err, locked);
      end
   endtask

   task automatic test_random();
      int s;
      bit en, clr;
      for (int i = 0; i < 600; i++) begin
         en  = ($urandom_range(0, 7) != 0);
         clr = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 3) == 0) s = $urandom_range(0, 7);
         else if (mode != 0) s = exp_m;
         else if (chain.size() > 0) s = (chain[$] + 1) % 5;
         else s = $urandom_range(0, 4);
         drive(en, s, clr);
         total++;
         if (locked !== (mode != 0) || err !== err_m || wrap !== wrap_m ||
             expected !== 3'(exp_m) || err_count !== 8'(cnt_m)) begin
            bad++;
            $display("FAIL random[%0d]: locked=%b err=%b wrap=%b exp=%0d cnt=%0d required %0d/%0d/%0d/%0d/%0d",
                     i, locked, err, wrap, expected, err_count, mode != 0, err_m, wrap_m, exp_m, cnt_m);
         end
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int i = 0; i < 4; i++) drive(1, i, 0);
      drive(1, 0, 0);
      total++;
      if (locked !== 1'b1 || err_count !== 8'd1 || expected !== 3'd0) begin
         bad++;
         $display("FAIL async_setup: locked=%b err_count=%0d expected=%0d required 1/1/0", locked, err_count, expected);
      end
      #2 reset_n = 0;
      #1;
      total++;
      if (locked !== 1'b0 || err_count !== 8'd0 || expected !== 3'd0 || err !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: locked=%b err_count=%0d expected=%0d err=%b required all 0",
                  locked, err_count, expected, err);
      end
      model_reset();
      @(negedge clock);
      reset_n = 1;
      @(negedge clock);
   endtask

   initial begin
      reset_n   = 0;
      sample_en = 0;
      S_in      = 0;
      clear_err = 0;
      model_reset();
      test_reset();
      test_lock_sequence();
      test_wrap();
      test_suspect_recover();
      test_unlock_relock();
      test_hunt_break();
      test_idle_hold();
      test_saturation();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
